// File: rtl/spi_xil_pkg.sv
// Shared sizing and types for the SPI Xilinx BRAM buffers.
// The top and the RAM sub-module both import this package.
package spi_xil_pkg;

    localparam int unsigned SPI_DW    = 8;
    localparam int unsigned SPI_AW    = 11;
    localparam int unsigned SPI_DEPTH = 2 ** SPI_AW;

    typedef logic [SPI_DW-1:0] spi_byte_t;
    typedef logic [SPI_AW-1:0] spi_ptr_t;

endpackage

// File: rtl/spi_xil_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
// The read register reset maps onto the BRAM output-latch reset value.
module spi_xil_sdp_ram
    import spi_xil_pkg::*;
#(
    parameter int unsigned DW = SPI_DW,
    parameter int unsigned AW = SPI_AW
) (
    input  logic          clka0,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clka0) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clka0) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_xil_bram_in.sv
// Transmit-side byte ring buffer feeding the SPI engine.
// Pointers wrap naturally; full/empty are resolved by the registered fill level only.
module spi_xil_bram_in
    import spi_xil_pkg::*;
#(
    parameter int unsigned DW = SPI_DW,
    parameter int unsigned AW = SPI_AW
) (
    input  logic          clka0,
    input  logic          rstn,
    input  logic          clr0,
    input  logic          wen0,
    input  logic [DW-1:0] wdata0,
    output logic          full0,
    input  logic          ren0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid0,
    output logic          not_empty0,
    output logic [AW:0]   count0,
    output logic          ovf0,
    output logic          udf0
);

    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_we;
    logic          ram_re;

    assign full0      = (count0 == FULL_LEVEL);
    assign not_empty0 = (count0 != '0);

    // Acceptance is judged on the pre-edge level, so empty+read and full+write
    // both reject even though the opposite request changes the level this cycle.
    always_comb begin
        wr_acc = wen0 && !full0;
        rd_acc = ren0 && not_empty0;
        ram_we = rstn && !clr0 && wr_acc;
        ram_re = rstn && !clr0 && rd_acc;
    end

    always_ff @(posedge clka0) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            count0  <= '0;
            rvalid0 <= 1'b0;
            ovf0    <= 1'b0;
            udf0    <= 1'b0;
        end else if (clr0) begin
            wptr    <= '0;
            rptr    <= '0;
            count0  <= '0;
            rvalid0 <= 1'b0;
            ovf0    <= 1'b0;
            udf0    <= 1'b0;
        end else begin
            rvalid0 <= rd_acc;
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            if (wen0 && full0) begin
                ovf0 <= 1'b1;
            end
            if (ren0 && !not_empty0) begin
                udf0 <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count0 <= count0 + (AW+1)'(1);
                2'b01:   count0 <= count0 - (AW+1)'(1);
                default: count0 <= count0;
            endcase
        end
    end

    spi_xil_sdp_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clka0 (clka0),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (wdata0),
        .re    (ram_re),
        .raddr (rptr),
        .rdata (rdata0)
    );

endmodule

// File: tb/tb_spi_xil_bram_in.sv
// Bench for spi_xil_bram_in: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the buffer.
module tb_spi_xil_bram_in;

    localparam int unsigned DEPTH = 2048;

    logic        clka0 = 1'b0;
    logic        rstn = 1'b0;
    logic        clr0 = 1'b0;
    logic        wen0 = 1'b0;
    logic [7:0]  wdata0 = '0;
    logic        full0;
    logic        ren0 = 1'b0;
    logic [7:0]  rdata0;
    logic        rvalid0;
    logic        not_empty0;
    logic [11:0] count0;
    logic        ovf0;
    logic        udf0;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_rdata = '0;
    logic       m_rvalid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    int unsigned rv_seen = 0;

    always #5 clka0 = ~clka0;

    spi_xil_bram_in #(
        .DW(8),
        .AW(11)
    ) dut (
        .clka0      (clka0),
        .rstn       (rstn),
        .clr0       (clr0),
        .wen0       (wen0),
        .wdata0     (wdata0),
        .full0      (full0),
        .ren0       (ren0),
        .rdata0     (rdata0),
        .rvalid0    (rvalid0),
        .not_empty0 (not_empty0),
        .count0     (count0),
        .ovf0       (ovf0),
        .udf0       (udf0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count0", 32'(count0), 32'(m_q.size()));
        check("full0", 32'(full0), 32'(m_q.size() == DEPTH));
        check("not_empty0", 32'(not_empty0), 32'(m_q.size() != 0));
        check("rvalid0", 32'(rvalid0), 32'(m_rvalid));
        check("rdata0", 32'(rdata0), 32'(m_rdata));
        check("ovf0", 32'(ovf0), 32'(m_ovf));
        check("udf0", 32'(udf0), 32'(m_udf));
    endtask

    // One clock: drive requests, apply the buffer rules to the model, compare after the edge.
    task automatic step(input logic rs_n, input logic cl, input logic we,
                        input logic [7:0] wd, input logic re);
        bit was_full;
        bit was_empty;
        rstn   = rs_n;
        clr0   = cl;
        wen0   = we;
        wdata0 = wd;
        ren0   = re;
        @(posedge clka0);
        if (!rs_n) begin
            m_q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else if (cl) begin
            m_q.delete();
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            m_rvalid  = 1'b0;
            if (re) begin
                if (!was_empty) begin
                    m_rdata  = m_q.pop_front();
                    m_rvalid = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (we) begin
                if (!was_full) m_q.push_back(wd);
                else           m_ovf = 1'b1;
            end
        end
        #1;
        if (rvalid0 === 1'b1) rv_seen++;
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2;
        // Reset held two edges with requests active.
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        check("reset_count_const", 32'(count0), 32'd0);
        check("reset_rdata_const", 32'(rdata0), 32'h00);
        idle();
        check("reset_no_write", 32'(not_empty0), 32'd0);

        // Ordering.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
        rv_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        check("order_rvalid_cycles", 32'(rv_seen), 32'd5);
        check("order_last_byte", 32'(rdata0), 32'h04);

        // Full and overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
        check("full_count_const", 32'(count0), 32'd2048);
        check("full_flag_const", 32'(full0), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        check("ovf_set_const", 32'(ovf0), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("first_pop_const", 32'(rdata0), 32'h00);
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("last_pop_const", 32'(rdata0), 32'hFF);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Wrap: fill, half drain, refill from A0, full drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        check("wrap_full_const", 32'(full0), 32'd1);
        rv_seen = 0;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        check("wrap_no_gap", 32'(rv_seen), 32'(DEPTH));

        // Simultaneous requests at level 3, then at empty.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
        check("simul_count_const", 32'(count0), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        check("empty_simul_udf_const", 32'(udf0), 32'd1);
        check("empty_simul_rvalid_const", 32'(rvalid0), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("no_bypass_data_const", 32'(rdata0), 32'h77);

        // Underflow, then flush with level 5 and a read in flight.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("pre_clr_rvalid_const", 32'(rvalid0), 32'd1);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        check("clr_rvalid_const", 32'(rvalid0), 32'd0);
        check("clr_count_const", 32'(count0), 32'd0);
        check("clr_rdata_hold_const", 32'(rdata0), 32'hC0);
        idle();

        // Random traffic in alternating write-heavy / read-heavy phases.
        for (int p = 0; p < 8; p++) begin
            int unsigned wp;
            wp = (p % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 300; i++) begin
                logic rs_n, cl, we, re;
                rs_n = ($urandom_range(0, 399) != 0);
                cl   = ($urandom_range(0, 199) == 0);
                we   = ($urandom_range(0, 99) < wp);
                re   = ($urandom_range(0, 99) < (100 - wp));
                step(rs_n, cl, we, 8'($urandom), re);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
